// File: rtl/caesar_clk_gate_if.sv
// Handshake/status bundle between the caesar clock-gate controller and its surroundings.
interface caesar_clk_gate_if #(
    parameter int unsigned CNT_W = 32
);
    logic             cg_enable_i;
    logic             busy_i;
    logic             req_valid_i;
    logic             wake_i;
    logic             clr_stats_i;
    logic             clk_en_o;
    logic             req_ready_o;
    logic             gated_o;
    logic [CNT_W-1:0] gated_cycles_o;

    modport master (
        output cg_enable_i, busy_i, req_valid_i, wake_i, clr_stats_i,
        input  clk_en_o, req_ready_o, gated_o, gated_cycles_o
    );

    modport slave (
        input  cg_enable_i, busy_i, req_valid_i, wake_i, clr_stats_i,
        output clk_en_o, req_ready_o, gated_o, gated_cycles_o
    );
endinterface

// File: rtl/caesar_clk_gate_ctrl.sv
// Activity-driven clock-enable controller for the caesar clock-gate wrapper.
// Runs on the free-running clock; gates after an idle run, stalls requests during wake-up.
module caesar_clk_gate_ctrl #(
    parameter int unsigned IDLE_CYCLES = 16,
    parameter int unsigned WAKE_CYCLES = 2,
    parameter int unsigned CNT_W       = 32
) (
    input logic               clk_i,
    input logic               rst_ni,
    caesar_clk_gate_if.slave  bus
);
    localparam int unsigned IDLE_W = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
    localparam int unsigned WAKE_W = (WAKE_CYCLES > 1) ? $clog2(WAKE_CYCLES) : 1;

    if (IDLE_CYCLES < 1) begin : g_bad_idle
        $error("caesar_clk_gate_ctrl: IDLE_CYCLES must be >= 1");
    end

    typedef enum logic [1:0] {
        ST_ON   = 2'd0,
        ST_WAKE = 2'd1,
        ST_OFF  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [IDLE_W-1:0]  idle_q, idle_d;
    logic [WAKE_W-1:0]  wake_q, wake_d;
    logic               clk_en_q, clk_en_d;
    logic               ready_q, ready_d;
    logic               gated_q, gated_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               activity;

    // State, counters and registered outputs
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= ST_ON;
            idle_q   <= '0;
            wake_q   <= '0;
            clk_en_q <= 1'b1;
            ready_q  <= 1'b1;
            gated_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            idle_q   <= idle_d;
            wake_q   <= wake_d;
            clk_en_q <= clk_en_d;
            ready_q  <= ready_d;
            gated_q  <= gated_d;
            cnt_q    <= cnt_d;
        end
    end

    // Next-state, counter and output decode
    always_comb begin
        state_d  = state_q;
        idle_d   = '0;
        wake_d   = '0;
        activity = bus.busy_i | bus.req_valid_i | bus.wake_i;

        unique case (state_q)
            ST_ON: begin
                // Activity at the threshold cycle keeps us ON with the counter cleared
                if (bus.cg_enable_i && !activity) begin
                    if (idle_q == IDLE_W'(IDLE_CYCLES - 1)) begin
                        state_d = ST_OFF;
                    end else begin
                        idle_d = idle_q + IDLE_W'(1);
                    end
                end
            end
            ST_OFF: begin
                if (activity || !bus.cg_enable_i) begin
                    state_d = (WAKE_CYCLES == 0) ? ST_ON : ST_WAKE;
                end
            end
            ST_WAKE: begin
                // Fixed window: inputs during WAKE neither shorten nor restart it
                if (wake_q == WAKE_W'(WAKE_CYCLES - 1)) begin
                    state_d = ST_ON;
                end else begin
                    wake_d = wake_q + WAKE_W'(1);
                end
            end
            default: state_d = ST_ON;
        endcase

        clk_en_d = (state_d != ST_OFF);
        ready_d  = (state_d == ST_ON);
        gated_d  = (state_d == ST_OFF);

        cnt_d = cnt_q;
        if (bus.clr_stats_i) begin
            cnt_d = '0;
        end else if (!clk_en_q && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign bus.clk_en_o       = clk_en_q;
    assign bus.req_ready_o    = ready_q;
    assign bus.gated_o        = gated_q;
    assign bus.gated_cycles_o = cnt_q;
endmodule

// File: tb/tb_caesar_clk_gate_ctrl.sv
// Table-driven bench for caesar_clk_gate_ctrl with a scoreboard queue of expected outputs.
module tb_caesar_clk_gate_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    caesar_clk_gate_if #(.CNT_W(32)) bus ();
    caesar_clk_gate_if #(.CNT_W(4))  sat_bus ();

    caesar_clk_gate_ctrl #(.IDLE_CYCLES(16), .WAKE_CYCLES(2), .CNT_W(32)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus.slave)
    );

    caesar_clk_gate_ctrl #(.IDLE_CYCLES(1), .WAKE_CYCLES(0), .CNT_W(4)) dut_sat (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (sat_bus.slave)
    );

    assign sat_bus.cg_enable_i = bus.cg_enable_i;
    assign sat_bus.busy_i      = bus.busy_i;
    assign sat_bus.req_valid_i = bus.req_valid_i;
    assign sat_bus.wake_i      = bus.wake_i;
    assign sat_bus.clr_stats_i = bus.clr_stats_i;

    // inputs packed as {rst_n, cg_enable, busy, req_valid, wake, clr_stats}
    localparam logic [5:0] I_RST   = 6'b010000;
    localparam logic [5:0] I_IDLE  = 6'b110000;
    localparam logic [5:0] I_BUSY  = 6'b111000;
    localparam logic [5:0] I_REQ   = 6'b110100;
    localparam logic [5:0] I_WAKE  = 6'b110010;
    localparam logic [5:0] I_CLR   = 6'b110001;
    localparam logic [5:0] I_CGOFF = 6'b100000;
    // outputs packed as {clk_en, req_ready, gated}
    localparam logic [2:0] O_ON    = 3'b110;
    localparam logic [2:0] O_WAKE  = 3'b100;
    localparam logic [2:0] O_OFF   = 3'b001;

    typedef struct {
        string      name;
        bit         sat;
        logic [5:0] in;
        int         reps;
        logic [2:0] out;
        int         cnt;
    } vec_t;

    typedef struct {
        string       name;
        bit          sat;
        logic [2:0]  out;
        bit          chk_cnt;
        logic [31:0] cnt;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];

    function automatic vec_t v(string name, bit sat, logic [5:0] in, int reps,
                               logic [2:0] out, int cnt);
        vec_t r;
        r.name = name; r.sat = sat; r.in = in; r.reps = reps; r.out = out; r.cnt = cnt;
        return r;
    endfunction

    task automatic cmp(string name, string field, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s %s: got %0d expected %0d", name, field, got, exp);
        end
    endtask

    task automatic check_front();
        exp_t        e;
        logic [2:0]  got;
        logic [31:0] got_cnt;
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard: got empty queue expected an entry");
            return;
        end
        e = exp_q.pop_front();
        if (e.sat) begin
            got     = {sat_bus.clk_en_o, sat_bus.req_ready_o, sat_bus.gated_o};
            got_cnt = 32'(sat_bus.gated_cycles_o);
        end else begin
            got     = {bus.clk_en_o, bus.req_ready_o, bus.gated_o};
            got_cnt = bus.gated_cycles_o;
        end
        cmp(e.name, "clk_en",    32'(got[2]), 32'(e.out[2]));
        cmp(e.name, "req_ready", 32'(got[1]), 32'(e.out[1]));
        cmp(e.name, "gated",     32'(got[0]), 32'(e.out[0]));
        if (e.chk_cnt) cmp(e.name, "gated_cycles", got_cnt, e.cnt);
    endtask

    initial begin
        bus.cg_enable_i = 1'b0;
        bus.busy_i      = 1'b0;
        bus.req_valid_i = 1'b0;
        bus.wake_i      = 1'b0;
        bus.clr_stats_i = 1'b0;

        vecs.push_back(v("reset",      0, I_RST,   2,   O_ON,   0));
        vecs.push_back(v("idle_pre",   0, I_IDLE,  15,  O_ON,   -1));
        vecs.push_back(v("gate",       0, I_IDLE,  1,   O_OFF,  0));
        vecs.push_back(v("off_hold",   0, I_IDLE,  3,   O_OFF,  3));
        vecs.push_back(v("req_w1",     0, I_REQ,   1,   O_WAKE, 4));
        vecs.push_back(v("req_w2",     0, I_REQ,   1,   O_WAKE, 4));
        vecs.push_back(v("req_rdy",    0, I_REQ,   1,   O_ON,   4));
        vecs.push_back(v("req_acc",    0, I_REQ,   1,   O_ON,   -1));
        vecs.push_back(v("idle10",     0, I_IDLE,  10,  O_ON,   -1));
        vecs.push_back(v("busy_pulse", 0, I_BUSY,  1,   O_ON,   -1));
        vecs.push_back(v("idle15",     0, I_IDLE,  15,  O_ON,   -1));
        vecs.push_back(v("gate2",      0, I_IDLE,  1,   O_OFF,  4));
        vecs.push_back(v("cgoff_wake", 0, I_CGOFF, 2,   O_WAKE, 5));
        vecs.push_back(v("cgoff_on",   0, I_CGOFF, 1,   O_ON,   -1));
        vecs.push_back(v("cgoff_100",  0, I_CGOFF, 100, O_ON,   5));
        vecs.push_back(v("idle15b",    0, I_IDLE,  15,  O_ON,   -1));
        vecs.push_back(v("gate3",      0, I_IDLE,  1,   O_OFF,  5));
        vecs.push_back(v("wake_in",    0, I_WAKE,  1,   O_WAKE, 6));
        vecs.push_back(v("busy_wake",  0, I_BUSY,  1,   O_WAKE, -1));
        vecs.push_back(v("busy_on",    0, I_BUSY,  2,   O_ON,   6));
        vecs.push_back(v("clr_on",     0, I_CLR,   1,   O_ON,   0));
        vecs.push_back(v("idle14",     0, I_IDLE,  14,  O_ON,   -1));
        vecs.push_back(v("gate4",      0, I_IDLE,  1,   O_OFF,  0));
        vecs.push_back(v("off40",      0, I_IDLE,  40,  O_OFF,  40));
        vecs.push_back(v("clr_off",    0, I_CLR,   1,   O_OFF,  0));
        vecs.push_back(v("resume1",    0, I_IDLE,  1,   O_OFF,  1));
        vecs.push_back(v("resume6",    0, I_IDLE,  5,   O_OFF,  6));
        vecs.push_back(v("rst_off",    0, I_RST,   1,   O_ON,   0));
        vecs.push_back(v("idle15c",    0, I_IDLE,  15,  O_ON,   -1));
        vecs.push_back(v("gate5",      0, I_IDLE,  1,   O_OFF,  0));
        vecs.push_back(v("req_wake",   0, I_REQ,   1,   O_WAKE, 1));
        vecs.push_back(v("rst_wake",   0, I_RST,   1,   O_ON,   0));
        vecs.push_back(v("post_rst",   0, I_IDLE,  15,  O_ON,   -1));
        vecs.push_back(v("post_gate",  0, I_IDLE,  1,   O_OFF,  0));
        vecs.push_back(v("sat_rst",    1, I_RST,   1,   O_ON,   0));
        vecs.push_back(v("sat_gate",   1, I_IDLE,  1,   O_OFF,  0));
        vecs.push_back(v("sat_cnt",    1, I_IDLE,  15,  O_OFF,  15));
        vecs.push_back(v("sat_hold",   1, I_IDLE,  5,   O_OFF,  15));
        vecs.push_back(v("sat_req",    1, I_REQ,   1,   O_ON,   15));
        vecs.push_back(v("sat_regate", 1, I_IDLE,  1,   O_OFF,  15));
        vecs.push_back(v("sat_clr",    1, I_CLR,   1,   O_OFF,  0));

        foreach (vecs[i]) begin
            for (int r = 0; r < vecs[i].reps; r++) begin
                exp_t e;
                @(negedge clk);
                {rst_n, bus.cg_enable_i, bus.busy_i, bus.req_valid_i,
                 bus.wake_i, bus.clr_stats_i} = vecs[i].in;
                e.name    = vecs[i].name;
                e.sat     = vecs[i].sat;
                e.out     = vecs[i].out;
                e.chk_cnt = (vecs[i].cnt >= 0) && (r == vecs[i].reps - 1);
                e.cnt     = 32'(vecs[i].cnt);
                exp_q.push_back(e);
                @(posedge clk);
                #1;
                check_front();
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timed out");
    end
endmodule

// File: doc/caesar_clk_gate_ctrl.md
Name: caesar_clk_gate_ctrl

Overview:
Activity-driven controller that produces the enable for the caesar clock-gating cell wrapper. It runs on the free-running (ungated) clock and watches caesar busy status and incoming bus requests. It drops the clock enable after a programmable number of consecutive idle cycles. On a new request it re-enables the clock, stalls the requester for a fixed wake-up window, then grants. It also keeps a saturating count of gated cycles for power statistics.

Parameters:
IDLE_CYCLES, 16, consecutive idle cycles required before gating (must be >= 1)
WAKE_CYCLES, 2, cycles between clock re-enable and req_ready_o assertion (0 allowed)
CNT_W, 32, width of the gated-cycle statistics counter

Ports:
clk_i  input  1  free-running clock (never the gated clock)
rst_ni  input  1  synchronous active-low reset
cg_enable_i  input  1  software enable for automatic gating; 0 forces the clock on
busy_i  input  1  caesar internal activity (pipeline/engine busy)
req_valid_i  input  1  bus request pending toward caesar
wake_i  input  1  explicit wake-up (e.g. DMA or interrupt pre-warning)
clr_stats_i  input  1  synchronous clear of gated_cycles_o
clk_en_o  output  1  registered enable to the clock-gate wrapper en_i
req_ready_o  output  1  request may be accepted by caesar this cycle
gated_o  output  1  status: clock currently gated (state OFF)
gated_cycles_o  output  CNT_W  saturating count of cycles with clk_en_o=0

Behaviour:
- Single clock; reset is synchronous, active-low on rst_ni, sampled at the rising edge of clk_i.
- Reset values: state ON, clk_en_o=1, req_ready_o=1, gated_o=0, gated_cycles_o=0, idle and wake counters 0.
- activity = busy_i | req_valid_i | wake_i.
- State ON: clk_en_o=1, req_ready_o=1.
  - Each cycle with cg_enable_i=1 and activity=0 increments idle_cnt.
  - Any activity, or cg_enable_i=0, resets idle_cnt to 0.
  - When idle_cnt==IDLE_CYCLES-1 and the current cycle is idle with cg_enable_i=1, next state is OFF. clk_en_o is low from the cycle after the IDLE_CYCLES-th consecutive idle cycle.
- State OFF: clk_en_o=0, req_ready_o=0, gated_o=1.
  - If activity=1 or cg_enable_i=0, next state is WAKE (or ON directly when WAKE_CYCLES=0), and clk_en_o returns to 1 next cycle.
  - A request arriving in OFF is not lost: req_valid_i must be held by the requester until req_ready_o=1.
- State WAKE: clk_en_o=1, req_ready_o=0, gated_o=0.
  - wake_cnt counts from 0; after WAKE_CYCLES cycles in WAKE, next state is ON with idle_cnt=0.
  - Activity or deassertion of cg_enable_i during WAKE does not shorten or restart the window.
- Output timing:
  - clk_en_o and gated_o are registered, so the gating cell latch sees a glitch-free enable.
  - req_ready_o is decoded from the state register only; there is no combinational path from req_valid_i.
- Wake latency from req_valid_i rising in OFF to req_ready_o=1 is WAKE_CYCLES+1 cycles.
- gated_cycles_o:
  - Increments by 1 each cycle clk_en_o=0 and saturates at 2^CNT_W-1; no wrap-around.
  - clr_stats_i has priority: counter becomes 0 that edge even if gated.
- Simultaneous events: at the exact cycle idle_cnt would reach the threshold, activity wins and the block stays ON with idle_cnt=0.
- Reset mid-operation, in any state: next edge returns to ON/enabled with all counters cleared. The statistics counter is cleared as well.
- IDLE_CYCLES<1 is illegal; flag it with an elaboration-time assertion.

Test Plan:
- Reset, then all inputs idle with cg_enable_i=1, IDLE_CYCLES=16 -> clk_en_o stays 1 for 16 cycles after reset release, goes 0 on cycle 17, and gated_o=1 on that same cycle.
- Idle run of 10 cycles, 1-cycle busy_i pulse, then idle again -> clk_en_o never drops before 16 idle cycles following the pulse (the counter restarts).
- In OFF, assert and hold req_valid_i with WAKE_CYCLES=2 -> clk_en_o=1 next cycle, req_ready_o=1 exactly 3 cycles after req_valid_i rose, gated_o=0 from the first wake cycle.
- cg_enable_i=0 with 100 idle cycles -> clk_en_o constantly 1. Dropping cg_enable_i while OFF -> WAKE, then ON.
- Stay OFF for 40 cycles, then assert clr_stats_i on cycle 41 while still gated -> gated_cycles_o reads 40, then 0, then resumes counting. With CNT_W=4 -> saturates at 15.
- Assert rst_ni=0 for 1 cycle in the middle of WAKE (and separately in OFF) -> next cycle clk_en_o=1, req_ready_o=1, gated_cycles_o=0.
